aes_round_key_reverse_buffer: RTL and testbench

- Buffers the NR+1 round keys produced in forward order (round 0..NR) by the encryption key expansion.
- Serves those keys in reverse order (round NR..0) to the decryption datapath's AddRoundKey stage.
- Keys are retained after loading, so every ciphertext block replays the full reverse sequence without reloading.
- Sits between the key expansion unit (writer side) and the inverse-cipher round controller (reader side).

---
 rtl/aes_round_key_reverse_buffer.sv | 104 ++++++++++
 tb/tb_aes_round_key_reverse_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_reverse_buffer.sv
// Stores the NR+1 forward-order AES round keys from key expansion and replays
// them in reverse order (NR..0) for every block of the inverse cipher.
module aes_round_key_reverse_buffer #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_valid,
  input  logic [KEY_W-1:0] wr_key,
  output logic             wr_ready,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [KEY_W-1:0] rd_key,
  output logic [3:0]       rd_round,
  output logic             block_done,
  output logic             keys_loaded
);

  // count must be able to hold NR+1 once the set is complete
  localparam int CW = $clog2(NR + 2);
  localparam logic [CW-1:0] LAST_WR = CW'(NR);
  localparam logic [3:0]    TOP_RND = 4'(NR);

  typedef enum logic {LOAD, SERVE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;
  logic [3:0]      ptr, ptr_next;
  logic            done_next;
  logic            wr_fire, rd_fire;
  logic [KEY_W-1:0] mem [NR+1];

  assign wr_ready    = (state == LOAD);
  assign keys_loaded = (state == SERVE);
  assign rd_valid    = (state == SERVE);
  assign wr_fire     = wr_valid && wr_ready;
  assign rd_fire     = rd_valid && rd_ready;

  // Zero-latency read port; outputs are forced to zero outside SERVE.
  assign rd_key   = rd_valid ? mem[ptr] : '0;
  assign rd_round = rd_valid ? ptr : 4'd0;

  // NOTE: the key storage has no reset; a stale entry is never visible because
  // rd_valid only rises after all NR+1 entries have been rewritten.
  always_ff @(posedge clk) begin
    if (wr_fire && !clear) mem[count] <= wr_key;
  end

  // NOTE: every signal gets its default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    count_next = count;
    ptr_next   = ptr;
    done_next  = 1'b0;
    if (clear) begin
      state_next = LOAD;
      count_next = '0;
      ptr_next   = TOP_RND;
    end else begin
      case (state)
        LOAD: begin
          if (wr_fire) begin
            count_next = count + 1'b1;
            if (count == LAST_WR) begin
              state_next = SERVE;
              ptr_next   = TOP_RND;
            end
          end
        end
        SERVE: begin
          if (rd_fire) begin
            if (ptr == 4'd0) begin
              ptr_next  = TOP_RND;
              done_next = 1'b1;
            end else begin
              ptr_next = ptr - 4'd1;
            end
          end
        end
        default: state_next = LOAD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      count      <= '0;
      ptr        <= TOP_RND;
      block_done <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      ptr        <= ptr_next;
      block_done <= done_next;
    end
  end

endmodule

// File: tb/tb_aes_round_key_reverse_buffer.sv
// Randomized self-checking bench: the expected read order is derived from the
// count of accepted reads against the table of keys that was written.
module tb_aes_round_key_reverse_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, clear;
  logic         wr_valid, wr_ready, rd_ready, rd_valid, block_done, keys_loaded;
  logic [127:0] wr_key, rd_key;
  logic [3:0]   rd_round;
  logic         wr_valid14, wr_ready14, rd_ready14, rd_valid14, block_done14, keys_loaded14;
  logic [127:0] wr_key14, rd_key14;
  logic [3:0]   rd_round14;

  aes_round_key_reverse_buffer #(.NR(10), .KEY_W(128)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .wr_valid(wr_valid), .wr_key(wr_key), .wr_ready(wr_ready),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_key(rd_key), .rd_round(rd_round),
    .block_done(block_done), .keys_loaded(keys_loaded)
  );

  aes_round_key_reverse_buffer #(.NR(14), .KEY_W(128)) dut14 (
    .clk(clk), .reset(reset), .clear(clear),
    .wr_valid(wr_valid14), .wr_key(wr_key14), .wr_ready(wr_ready14),
    .rd_ready(rd_ready14), .rd_valid(rd_valid14), .rd_key(rd_key14), .rd_round(rd_round14),
    .block_done(block_done14), .keys_loaded(keys_loaded14)
  );

  int checks   = 0;
  int failures = 0;
  int m_reads  = 0;
  logic [127:0] keys   [0:10];
  logic [127:0] keys14 [0:14];

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic load10(input bit gaps);
    int i = 0;
    int cyc = 0;
    while (i <= 10 && cyc < 400) begin
      wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_key   = wr_valid ? keys[i] : rand_key();
      rd_ready = 1'($urandom_range(0, 1));
      checks++;
      if (wr_ready !== 1'b1 || keys_loaded !== 1'b0 || rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL load_status write %0d: wr_ready=%b keys_loaded=%b rd_valid=%b expected 1 0 0", i, wr_ready, keys_loaded, rd_valid);
      end
      checks++;
      if (rd_key !== 128'd0 || rd_round !== 4'd0) begin
        failures++;
        $display("FAIL load_rd_zero: rd_key=%h rd_round=%0d expected 0 0", rd_key, rd_round);
      end
      @(posedge clk); #1;
      if (wr_valid) i++;
      cyc++;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    m_reads  = 0;
    checks++;
    if (i != 11) begin
      failures++;
      $display("FAIL load_timeout: accepted %0d writes expected 11", i);
    end
    checks++;
    if (keys_loaded !== 1'b1 || rd_valid !== 1'b1 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL loaded_status: keys_loaded=%b rd_valid=%b wr_ready=%b expected 1 1 0", keys_loaded, rd_valid, wr_ready);
    end
    checks++;
    if (rd_round !== 4'd10 || rd_key !== keys[10]) begin
      failures++;
      $display("FAIL first_read: round=%0d key=%h expected 10 %h", rd_round, rd_key, keys[10]);
    end
  endtask

  task automatic serve10(input int nreads, input bit random_ready, input bit random_wr);
    int got = 0;
    int cyc = 0;
    int er;
    bit exp_done = 1'b0;
    while (got < nreads && cyc < 2000) begin
      rd_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_valid = random_wr ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_key   = rand_key();
      er = 10 - (m_reads % 11);
      checks++;
      if (rd_valid !== 1'b1 || wr_ready !== 1'b0 || keys_loaded !== 1'b1) begin
        failures++;
        $display("FAIL serve_status: rd_valid=%b wr_ready=%b keys_loaded=%b expected 1 0 1", rd_valid, wr_ready, keys_loaded);
      end
      checks++;
      if (rd_round !== 4'(er) || rd_key !== keys[er]) begin
        failures++;
        $display("FAIL serve_data: round=%0d key=%h expected %0d %h", rd_round, rd_key, er, keys[er]);
      end
      checks++;
      if (block_done !== exp_done) begin
        failures++;
        $display("FAIL serve_block_done: got %b expected %b", block_done, exp_done);
      end
      @(posedge clk); #1;
      cyc++;
      exp_done = rd_ready && (er == 0);
      if (rd_ready) begin
        got++;
        m_reads++;
      end
    end
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (got != nreads) begin
      failures++;
      $display("FAIL serve_timeout: got %0d reads expected %0d", got, nreads);
    end
    checks++;
    if (block_done !== exp_done) begin
      failures++;
      $display("FAIL serve_end_done: got %b expected %b", block_done, exp_done);
    end
    @(posedge clk); #1;
    checks++;
    if (block_done !== 1'b0 || rd_round !== 4'(10 - (m_reads % 11))) begin
      failures++;
      $display("FAIL serve_idle: block_done=%b round=%0d expected 0 %0d", block_done, rd_round, 10 - (m_reads % 11));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || keys_loaded !== 1'b0 || block_done !== 1'b0 ||
        rd_key !== 128'd0 || rd_round !== 4'd0) begin
      failures++;
      $display("FAIL reset_values: wr_ready=%b rd_valid=%b keys_loaded=%b block_done=%b rd_key=%h rd_round=%0d",
               wr_ready, rd_valid, keys_loaded, block_done, rd_key, rd_round);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_load_basic();
    for (int i = 0; i <= 10; i++) keys[i] = 128'(i);
    load10(1'b0);
  endtask

  task automatic test_fips();
    keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    do_reset();
    load10(1'b0);
    serve10(11, 1'b0, 1'b0);
    serve10(11, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    bit       rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int       exp [4] = '{10, 9, 9, 9};
    for (int i = 0; i <= 10; i++) keys[i] = rand_key();
    do_reset();
    load10(1'b1);
    for (int i = 0; i < 4; i++) begin
      rd_ready = rdy[i];
      checks++;
      if (rd_round !== 4'(exp[i]) || rd_key !== keys[exp[i]]) begin
        failures++;
        $display("FAIL stall_step %0d: round=%0d key=%h expected %0d %h", i, rd_round, rd_key, exp[i], keys[exp[i]]);
      end
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    m_reads  = 2;
    checks++;
    if (rd_round !== 4'd8 || rd_key !== keys[8]) begin
      failures++;
      $display("FAIL stall_final: round=%0d expected 8", rd_round);
    end
    serve10(30, 1'b1, 1'b1);
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_key   = rand_key();
      @(posedge clk); #1;
    end
    wr_key = rand_key();
    clear  = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (wr_ready !== 1'b1 || keys_loaded !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_load: wr_ready=%b keys_loaded=%b rd_valid=%b expected 1 0 0", wr_ready, keys_loaded, rd_valid);
    end
    for (int i = 0; i <= 10; i++) keys[i] = rand_key();
    load10(1'b1);
    serve10(21, 1'b1, 1'b1);
    rd_ready = 1'b1;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    rd_ready = 1'b0;
    checks++;
    if (block_done !== 1'b0 || wr_ready !== 1'b1 || rd_valid !== 1'b0 || rd_round !== 4'd0) begin
      failures++;
      $display("FAIL clear_priority: block_done=%b wr_ready=%b rd_valid=%b round=%0d expected 0 1 0 0",
               block_done, wr_ready, rd_valid, rd_round);
    end
    load10(1'b0);
    serve10(11, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i <= 10; i++) keys[i] = rand_key();
    do_reset();
    load10(1'b0);
    serve10(6, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || keys_loaded !== 1'b0 || wr_ready !== 1'b1 || rd_key !== 128'd0 ||
        rd_round !== 4'd0 || block_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: rd_valid=%b keys_loaded=%b wr_ready=%b rd_key=%h rd_round=%0d",
               rd_valid, keys_loaded, wr_ready, rd_key, rd_round);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i <= 10; i++) keys[i] = rand_key();
    load10(1'b1);
    serve10(11, 1'b1, 1'b0);
  endtask

  task automatic test_nr14();
    int cyc = 0;
    do_reset();
    for (int i = 0; i <= 14; i++) keys14[i] = rand_key();
    for (int i = 0; i <= 14; i++) begin
      wr_valid14 = 1'b1;
      wr_key14   = keys14[i];
      checks++;
      if (wr_ready14 !== 1'b1 || keys_loaded14 !== 1'b0) begin
        failures++;
        $display("FAIL nr14_load %0d: wr_ready=%b keys_loaded=%b expected 1 0", i, wr_ready14, keys_loaded14);
      end
      @(posedge clk); #1;
    end
    wr_valid14 = 1'b0;
    for (int i = 0; i <= 14; i++) begin
      rd_ready14 = 1'b1;
      checks++;
      if (rd_valid14 !== 1'b1 || rd_round14 !== 4'(14 - i) || rd_key14 !== keys14[14 - i] || block_done14 !== 1'b0) begin
        failures++;
        $display("FAIL nr14_read %0d: valid=%b round=%0d key=%h done=%b expected round %0d key %h",
                 i, rd_valid14, rd_round14, rd_key14, block_done14, 14 - i, keys14[14 - i]);
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_ready14 = 1'b0;
    checks++;
    if (block_done14 !== 1'b1 || rd_round14 !== 4'd14 || cyc != 15) begin
      failures++;
      $display("FAIL nr14_done: block_done=%b round=%0d expected 1 14", block_done14, rd_round14);
    end
    @(posedge clk); #1;
    checks++;
    if (block_done14 !== 1'b0) begin
      failures++;
      $display("FAIL nr14_pulse: block_done=%b expected 0", block_done14);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    wr_valid = 1'b0; wr_key = '0; rd_ready = 1'b0;
    wr_valid14 = 1'b0; wr_key14 = '0; rd_ready14 = 1'b0;
    test_reset();
    test_load_basic();
    test_fips();
    test_stall();
    test_clear();
    test_async_reset();
    test_nr14();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
